// File: rtl/wb_stage.sv
// Write-back stage: retires one instruction per handshake, formats load data and drives the
// register-file write port. Optional macro WB_BYPASS_EN adds the fwd_* forwarding outputs.
module wb_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rd,
    input  logic             in_rd_wen,
    input  logic             in_is_load,
    input  logic [2:0]       in_funct3,
    input  logic [1:0]       in_addr_lo,
    input  logic [XLEN-1:0]  in_result,
    input  logic             dmem_rvalid,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic             Wen,
    output logic [4:0]       Wnum,
    output logic [XLEN-1:0]  Wd,
    output logic             busy,
    output logic [CNT_W-1:0] retire_cnt
`ifdef WB_BYPASS_EN
    ,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rnum,
    output logic [XLEN-1:0]  fwd_data
`endif
);

    typedef enum logic [1:0] {StIdle, StWaitMem, StCommit} state_e;

    state_e            state_q, state_d;
    logic              xfer, load_done, commit;

    // Commit-side registers double as the held Wnum/Wd values between commits.
    logic [4:0]        wnum_q;
    logic [XLEN-1:0]   wd_q;
    logic              wen_q;

    logic [4:0]        ld_rd_q;
    logic              ld_wen_q;
    logic [2:0]        ld_funct3_q;
    logic [1:0]        ld_addr_lo_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   ld_fmt;

    always_comb begin
        state_d   = state_q;
        in_ready  = (state_q != StWaitMem);
        xfer      = in_valid & in_ready;
        commit    = (state_q == StCommit);
        load_done = (state_q == StWaitMem) & dmem_rvalid;
        unique case (state_q)
            StIdle, StCommit: begin
                if (xfer) state_d = in_is_load ? StWaitMem : StCommit;
                else      state_d = StIdle;
            end
            StWaitMem: if (dmem_rvalid) state_d = StCommit;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        ld_byte = dmem_rdata[7:0];
        unique case (ld_addr_lo_q)
            2'd0: ld_byte = dmem_rdata[7:0];
            2'd1: ld_byte = dmem_rdata[15:8];
            2'd2: ld_byte = dmem_rdata[23:16];
            2'd3: ld_byte = dmem_rdata[31:24];
            default: ld_byte = dmem_rdata[7:0];
        endcase
        // addr_lo[0] is ignored for halfwords; misalignment never reaches this stage.
        ld_half = ld_addr_lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (ld_funct3_q)
            3'b000:  ld_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  ld_fmt = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  ld_fmt = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_fmt = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wnum_q       <= '0;
            wd_q         <= '0;
            wen_q        <= 1'b0;
            ld_rd_q      <= '0;
            ld_wen_q     <= 1'b0;
            ld_funct3_q  <= '0;
            ld_addr_lo_q <= '0;
            cnt_q        <= '0;
        end else begin
            if (xfer && !in_is_load) begin
                wnum_q <= in_rd;
                wd_q   <= in_result;
                wen_q  <= in_rd_wen;
            end
            if (xfer && in_is_load) begin
                ld_rd_q      <= in_rd;
                ld_wen_q     <= in_rd_wen;
                ld_funct3_q  <= in_funct3;
                ld_addr_lo_q <= in_addr_lo;
            end
            if (load_done) begin
                wnum_q <= ld_rd_q;
                wd_q   <= ld_fmt;
                wen_q  <= ld_wen_q;
            end
            if (commit) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign Wen        = commit & wen_q & (wnum_q != 5'd0);
    assign Wnum       = wnum_q;
    assign Wd         = wd_q;
    assign busy       = (state_q == StWaitMem);
    assign retire_cnt = cnt_q;

`ifdef WB_BYPASS_EN
    assign fwd_valid = Wen;
    assign fwd_rnum  = Wnum;
    assign fwd_data  = Wd;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: transaction-level model compared every cycle, plus
// directed literal checks. Define WB_BYPASS_EN to also check the fwd_* outputs.
module tb_wb_stage;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  in_rd;
    logic        in_rd_wen, in_is_load;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_result;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        Wen;
    logic [4:0]  Wnum;
    logic [31:0] Wd;
    logic        busy;
    logic [31:0] retire_cnt;
`ifdef WB_BYPASS_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rnum;
    logic [31:0] fwd_data;
`endif

    int vectors     = 0;
    int miscompares = 0;

    wb_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rd       (in_rd),
        .in_rd_wen   (in_rd_wen),
        .in_is_load  (in_is_load),
        .in_funct3   (in_funct3),
        .in_addr_lo  (in_addr_lo),
        .in_result   (in_result),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .Wen         (Wen),
        .Wnum        (Wnum),
        .Wd          (Wd),
        .busy        (busy),
        .retire_cnt  (retire_cnt)
`ifdef WB_BYPASS_EN
        ,
        .fwd_valid   (fwd_valid),
        .fwd_rnum    (fwd_rnum),
        .fwd_data    (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Load formatting from the ISA rules, by shifting and sign-casting.
    function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] alo,
                                        input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic        hi;
        hi = alo[1];
        b  = 8'(w >> (8 * alo));
        h  = 16'(w >> (16 * hi));
        case (f3)
            3'b000:  return 32'($signed(b));
            3'b001:  return 32'($signed(h));
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    // Model: at most one load outstanding; a commit is "due" in the cycle after it becomes known.
    logic        m_commit, m_wen, m_load_pend, m_ld_wen;
    logic [4:0]  m_wnum, m_ld_rd;
    logic [31:0] m_wd, m_cnt;
    logic [2:0]  m_ld_f3;
    logic [1:0]  m_ld_alo;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_commit    <= 1'b0;
            m_wen       <= 1'b0;
            m_wnum      <= '0;
            m_wd        <= '0;
            m_cnt       <= '0;
            m_load_pend <= 1'b0;
            m_ld_wen    <= 1'b0;
            m_ld_rd     <= '0;
            m_ld_f3     <= '0;
            m_ld_alo    <= '0;
        end else begin
            if (m_commit) m_cnt <= m_cnt + 32'd1;
            m_commit <= 1'b0;
            if (m_load_pend && dmem_rvalid) begin
                m_commit    <= 1'b1;
                m_wen       <= m_ld_wen;
                m_wnum      <= m_ld_rd;
                m_wd        <= fmt(m_ld_f3, m_ld_alo, dmem_rdata);
                m_load_pend <= 1'b0;
            end else if (!m_load_pend && in_valid) begin
                if (in_is_load) begin
                    m_load_pend <= 1'b1;
                    m_ld_wen    <= in_rd_wen;
                    m_ld_rd     <= in_rd;
                    m_ld_f3     <= in_funct3;
                    m_ld_alo    <= in_addr_lo;
                end else begin
                    m_commit <= 1'b1;
                    m_wen    <= in_rd_wen;
                    m_wnum   <= in_rd;
                    m_wd     <= in_result;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic exp_wen;
        exp_wen = m_commit && m_wen && (m_wnum != 5'd0);
        chk("Wen", 32'(Wen), 32'(exp_wen));
        chk("Wnum", 32'(Wnum), 32'(m_wnum));
        chk("Wd", Wd, m_wd);
        chk("retire_cnt", retire_cnt, m_cnt);
        chk("busy", 32'(busy), 32'(m_load_pend));
        chk("in_ready", 32'(in_ready), 32'(!m_load_pend));
`ifdef WB_BYPASS_EN
        chk("fwd_valid", 32'(fwd_valid), 32'(exp_wen));
        chk("fwd_rnum", 32'(fwd_rnum), 32'(m_wnum));
        chk("fwd_data", fwd_data, m_wd);
`endif
    end

    task automatic drive(input logic ld, input logic [4:0] rd, input logic wen,
                         input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] res);
        in_valid   = 1'b1;
        in_is_load = ld;
        in_rd      = rd;
        in_rd_wen  = wen;
        in_funct3  = f3;
        in_addr_lo = alo;
        in_result  = res;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rv(input logic [31:0] d);
        in_valid    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = d;
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  alo;
        logic [31:0] word;
    } ld_vec_t;

    ld_vec_t ld_tab[5];

    initial begin
        ld_tab[0] = '{3'b001, 2'd0, 32'h1234_8001};
        ld_tab[1] = '{3'b010, 2'd1, 32'hCAFE_F00D};
        ld_tab[2] = '{3'b100, 2'd1, 32'h0000_AB00};
        ld_tab[3] = '{3'b011, 2'd2, 32'hA5A5_5A5A};
        ld_tab[4] = '{3'b000, 2'd1, 32'h0000_7F00};

        rst_n       = 1'b1;
        in_valid    = 1'b1;
        in_is_load  = 1'b0;
        in_rd       = 5'd9;
        in_rd_wen   = 1'b1;
        in_funct3   = 3'b000;
        in_addr_lo  = 2'd0;
        in_result   = 32'h5555_AAAA;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        idle(2);
        chk("rst_wen", 32'(Wen), 32'd0);
        chk("rst_cnt", retire_cnt, 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        drive(1'b0, 5'd5, 1'b1, 3'b000, 2'd0, 32'hDEAD_BEEF);
        in_valid = 1'b0;
        chk("nl_wen", 32'(Wen), 32'd1);
        chk("nl_wnum", 32'(Wnum), 32'd5);
        chk("nl_wd", Wd, 32'hDEAD_BEEF);
        idle(1);
        chk("nl_cnt", retire_cnt, 32'd1);

        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 5'(i), 1'b1, 3'b000, 2'd0, 32'h100 + 32'(i));
            chk("b2b_wen", 32'(Wen), 32'd1);
            chk("b2b_wnum", 32'(Wnum), 32'(i));
        end
        idle(1);
        chk("b2b_cnt", retire_cnt, 32'd5);

        drive(1'b1, 5'd7, 1'b1, 3'b000, 2'd3, 32'd0);
        in_valid = 1'b0;
        chk("lb_busy", 32'(busy), 32'd1);
        chk("lb_ready", 32'(in_ready), 32'd0);
        idle(2);
        rv(32'h80FF_0000);
        chk("lb_wen", 32'(Wen), 32'd1);
        chk("lb_wd", Wd, 32'hFFFF_FF80);
        idle(1);

        drive(1'b1, 5'd8, 1'b1, 3'b101, 2'd2, 32'd0);
        idle(2);
        rv(32'h80FF_0000);
        chk("lhu_wd", Wd, 32'h0000_80FF);
        idle(1);

        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'(10 + i), 1'b1, ld_tab[i].f3, ld_tab[i].alo, 32'd0);
            idle(1);
            rv(ld_tab[i].word);
            idle(1);
        end

        drive(1'b0, 5'd0, 1'b1, 3'b000, 2'd0, 32'h0000_1234);
        in_valid = 1'b0;
        chk("rd0_wen", 32'(Wen), 32'd0);
        idle(1);
        chk("rd0_cnt", retire_cnt, 32'd13);

        // Load accepted in COMMIT while a stray rvalid is present: must not be sampled.
        drive(1'b0, 5'd3, 1'b1, 3'b000, 2'd0, 32'd77);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hFFFF_FFFF;
        drive(1'b1, 5'd4, 1'b1, 3'b010, 2'd0, 32'd0);
        dmem_rvalid = 1'b0;
        in_valid    = 1'b0;
        chk("stray_busy", 32'(busy), 32'd1);
        idle(1);
        rv(32'h1357_9BDF);
        chk("stray_wd", Wd, 32'h1357_9BDF);
        chk("stray_wnum", 32'(Wnum), 32'd4);
        idle(1);

        drive(1'b1, 5'd6, 1'b1, 3'b010, 2'd0, 32'd0);
        in_valid = 1'b0;
        chk("rst_ld_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        rv(32'h1111_1111);
        chk("rst_ld_wen", 32'(Wen), 32'd0);
        chk("rst_ld_busy2", 32'(busy), 32'd0);
        idle(2);
        chk("rst_ld_cnt", retire_cnt, 32'd0);
        chk("rst_ld_wen2", 32'(Wen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
